// File: rtl/gemm_kslice_sequencer.sv
// K-slice sequencer feeding a 2x2 MAC array: one slice per array pass,
// partial sums fed back as acc*, final 2x2 tile on a valid/ready port.
// Ports: clk, rst_n (async, active-low); start/k_len/busy tile control;
//   s_* slice stream (valid/ready); arr_* array issue + result return;
//   res_* final tile (valid/ready).
// Build option: GEMM_SEQ_RELU_EN clamps negative results to 0 at res_y*.
module gemm_kslice_sequencer #(
  parameter int KMAX = 16,
  parameter int DW   = 8,
  parameter int AW   = 32,
  localparam int KW  = $clog2(KMAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_a0,
  input  logic signed [DW-1:0] s_a1,
  input  logic signed [DW-1:0] s_b0,
  input  logic signed [DW-1:0] s_b1,
  output logic                 arr_in_valid,
  output logic signed [DW-1:0] arr_a0,
  output logic signed [DW-1:0] arr_a1,
  output logic signed [DW-1:0] arr_b0,
  output logic signed [DW-1:0] arr_b1,
  output logic signed [AW-1:0] arr_acc00,
  output logic signed [AW-1:0] arr_acc01,
  output logic signed [AW-1:0] arr_acc10,
  output logic signed [AW-1:0] arr_acc11,
  input  logic                 arr_out_valid,
  input  logic signed [AW-1:0] arr_y00,
  input  logic signed [AW-1:0] arr_y01,
  input  logic signed [AW-1:0] arr_y10,
  input  logic signed [AW-1:0] arr_y11,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [AW-1:0] res_y00,
  output logic signed [AW-1:0] res_y01,
  output logic signed [AW-1:0] res_y10,
  output logic signed [AW-1:0] res_y11
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [KW-1:0] klen_q, cnt_q;
  logic [KW-1:0] klen_clamp, cnt_inc;
  logic signed [DW-1:0] a0_q, a1_q, b0_q, b1_q;
  logic signed [AW-1:0] acc_q  [4];
  logic signed [AW-1:0] part_q [4];
  logic signed [AW-1:0] y_w    [4];
  logic signed [AW-1:0] res_w  [4];

  logic start_acc, beat_acc, y_acc, last;

  assign klen_clamp = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
  assign cnt_inc    = cnt_q + KW'(1);
  assign last       = (cnt_inc == klen_q);

  assign start_acc = (state_q == S_IDLE)  && start;
  assign beat_acc  = (state_q == S_FETCH) && s_valid;
  assign y_acc     = (state_q == S_WAIT)  && arr_out_valid;

  assign y_w[0] = arr_y00;
  assign y_w[1] = arr_y01;
  assign y_w[2] = arr_y10;
  assign y_w[3] = arr_y11;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (klen_clamp == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: if (s_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (arr_out_valid) begin
          state_d = last ? S_DONE : S_FETCH;
        end
      end
      S_DONE: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      klen_q <= '0;
      cnt_q  <= '0;
      a0_q   <= '0;
      a1_q   <= '0;
      b0_q   <= '0;
      b1_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]  <= '0;
        part_q[i] <= '0;
      end
    end else begin
      if (start_acc) begin
        klen_q <= klen_clamp;
        cnt_q  <= '0;
        for (int i = 0; i < 4; i++) begin
          part_q[i] <= '0;
        end
      end
      if (beat_acc) begin
        a0_q <= s_a0;
        a1_q <= s_a1;
        b0_q <= s_b0;
        b1_q <= s_b1;
        for (int i = 0; i < 4; i++) begin
          acc_q[i] <= part_q[i];
        end
      end
      if (y_acc) begin
        cnt_q <= cnt_inc;
        for (int i = 0; i < 4; i++) begin
          part_q[i] <= y_w[i];
        end
      end
    end
  end

  // Clamp only the presented tile; fed-back acc stays raw.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
`ifdef GEMM_SEQ_RELU_EN
      res_w[i] = part_q[i][AW-1] ? '0 : part_q[i];
`else
      res_w[i] = part_q[i];
`endif
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign s_ready      = (state_q == S_FETCH);
  assign arr_in_valid = (state_q == S_ISSUE);
  assign res_valid    = (state_q == S_DONE);

  assign arr_a0    = a0_q;
  assign arr_a1    = a1_q;
  assign arr_b0    = b0_q;
  assign arr_b1    = b1_q;
  assign arr_acc00 = acc_q[0];
  assign arr_acc01 = acc_q[1];
  assign arr_acc10 = acc_q[2];
  assign arr_acc11 = acc_q[3];

  assign res_y00 = res_w[0];
  assign res_y01 = res_w[1];
  assign res_y10 = res_w[2];
  assign res_y11 = res_w[3];

endmodule

// File: tb/tb_gemm_kslice_sequencer.sv
// Directed bench for gemm_kslice_sequencer with a behavioural 2x2 MAC
// array model of programmable latency.
module tb_gemm_kslice_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [4:0] k_len = '0;
  logic busy;
  logic s_valid = 1'b0;
  logic s_ready;
  logic signed [7:0] s_a0 = '0, s_a1 = '0, s_b0 = '0, s_b1 = '0;
  logic arr_in_valid;
  logic signed [7:0] arr_a0, arr_a1, arr_b0, arr_b1;
  logic signed [31:0] arr_acc00, arr_acc01, arr_acc10, arr_acc11;
  logic arr_out_valid;
  logic signed [31:0] arr_y00, arr_y01, arr_y10, arr_y11;
  logic res_valid;
  logic res_ready = 1'b0;
  logic signed [31:0] res_y00, res_y01, res_y10, res_y11;

  int pass_cnt = 0;
  int total_cnt = 0;

  // array model state
  int lat = 1;
  int pend = 0;
  int issue_cnt = 0;
  logic m_ov = 1'b0;
  logic stray = 1'b0;
  logic signed [31:0] m_y [4];
  logic signed [31:0] log_acc [64][4];

  assign arr_out_valid = m_ov | stray;
  assign arr_y00 = stray ? 32'sd999 : m_y[0];
  assign arr_y01 = stray ? 32'sd999 : m_y[1];
  assign arr_y10 = stray ? 32'sd999 : m_y[2];
  assign arr_y11 = stray ? 32'sd999 : m_y[3];

  always #5 clk = ~clk;

  gemm_kslice_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .k_len(k_len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_a0(s_a0), .s_a1(s_a1), .s_b0(s_b0), .s_b1(s_b1),
    .arr_in_valid(arr_in_valid),
    .arr_a0(arr_a0), .arr_a1(arr_a1),
    .arr_b0(arr_b0), .arr_b1(arr_b1),
    .arr_acc00(arr_acc00), .arr_acc01(arr_acc01),
    .arr_acc10(arr_acc10), .arr_acc11(arr_acc11),
    .arr_out_valid(arr_out_valid),
    .arr_y00(arr_y00), .arr_y01(arr_y01),
    .arr_y10(arr_y10), .arr_y11(arr_y11),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y00(res_y00), .res_y01(res_y01),
    .res_y10(res_y10), .res_y11(res_y11)
  );

  // Behavioural MAC array: y = acc + outer(a, b), out_valid lat cycles
  // after the issue cycle.
  initial begin
    for (int i = 0; i < 4; i++) m_y[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        m_ov = 1'b0;
      end else begin
        m_ov = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) m_ov = 1'b1;
        end
        if (arr_in_valid) begin
          m_y[0] = arr_acc00 + arr_a0 * arr_b0;
          m_y[1] = arr_acc01 + arr_a0 * arr_b1;
          m_y[2] = arr_acc10 + arr_a1 * arr_b0;
          m_y[3] = arr_acc11 + arr_a1 * arr_b1;
          log_acc[issue_cnt % 64][0] = arr_acc00;
          log_acc[issue_cnt % 64][1] = arr_acc01;
          log_acc[issue_cnt % 64][2] = arr_acc10;
          log_acc[issue_cnt % 64][3] = arr_acc11;
          issue_cnt++;
          pend = lat;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input int kl);
    start = 1'b1;
    k_len = 5'(kl);
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input int a0, input int a1,
                           input int b0, input int b1,
                           input int gap);
    int n;
    repeat (gap) tick();
    s_a0 = 8'(a0);
    s_a1 = 8'(a1);
    s_b0 = 8'(b0);
    s_b1 = 8'(b1);
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      total_cnt++;
      $display("FAIL beat_timeout s_ready=%b required 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      total_cnt++;
      $display("FAIL res_timeout res_valid=%b required 1", res_valid);
    end
  endtask

  task automatic handshake(input string nm);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total_cnt++;
    if ({res_valid, busy} !== 2'b00) begin
      $display("FAIL %s_after_hs valid,busy=%b required 00",
               nm, {res_valid, busy});
    end else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if ({busy, s_ready, arr_in_valid, res_valid} !== 4'b0000) begin
      $display("FAIL reset_ctrl got %b required 0000",
               {busy, s_ready, arr_in_valid, res_valid});
    end else pass_cnt++;
    total_cnt++;
    if ({res_y00, res_y01, res_y10, res_y11, arr_acc00, arr_a0}
        !== '0) begin
      $display("FAIL reset_data res=%0d acc00=%0d a0=%0d required 0",
               res_y00, arr_acc00, arr_a0);
    end else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_release busy=%b required 0", busy);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    int base;
    base = issue_cnt;
    lat = 1;
    start_tile(2);
    send_beat(1, 3, 5, 6, 0);
    send_beat(2, 4, 7, 8, 0);
    wait_res();
    total_cnt++;
    if ({res_y00, res_y01, res_y10, res_y11} !==
        {32'sd19, 32'sd22, 32'sd43, 32'sd50}) begin
      $display("FAIL basic_res got %0d %0d %0d %0d required 19 22 43 50",
               res_y00, res_y01, res_y10, res_y11);
    end else pass_cnt++;
    total_cnt++;
    if ({log_acc[(base+1)%64][0], log_acc[(base+1)%64][1],
         log_acc[(base+1)%64][2], log_acc[(base+1)%64][3]} !==
        {32'sd5, 32'sd6, 32'sd15, 32'sd18}) begin
      $display("FAIL basic_acc2 got %0d %0d %0d %0d required 5 6 15 18",
               log_acc[(base+1)%64][0], log_acc[(base+1)%64][1],
               log_acc[(base+1)%64][2], log_acc[(base+1)%64][3]);
    end else pass_cnt++;
    total_cnt++;
    if (issue_cnt - base !== 2) begin
      $display("FAIL basic_issues got %0d required 2", issue_cnt - base);
    end else pass_cnt++;
    handshake("basic");
  endtask

  task automatic test_kzero();
    int base;
    int n;
    base = issue_cnt;
    start_tile(0);
    n = 0;
    while (!res_valid && n < 2) begin
      tick();
      n++;
    end
    total_cnt++;
    if (res_valid !== 1'b1) begin
      $display("FAIL kzero_valid res_valid=%b required 1", res_valid);
    end else pass_cnt++;
    total_cnt++;
    if ({res_y00, res_y01, res_y10, res_y11} !== '0) begin
      $display("FAIL kzero_res got %0d %0d %0d %0d required 0 0 0 0",
               res_y00, res_y01, res_y10, res_y11);
    end else pass_cnt++;
    total_cnt++;
    if (issue_cnt - base !== 0) begin
      $display("FAIL kzero_issues got %0d required 0", issue_cnt - base);
    end else pass_cnt++;
    handshake("kzero");
  endtask

  task automatic test_stall();
    logic signed [31:0] e3;
`ifdef GEMM_SEQ_RELU_EN
    e3 = 32'sd0;
`else
    e3 = -32'sd5;
`endif
    lat = 3;
    start_tile(3);
    send_beat(1, 0, 1, 0, 0);
    send_beat(2, 1, 1, 1, 2);
    send_beat(-1, 3, 2, -2, 4);
    wait_res();
    for (int c = 0; c < 5; c++) begin
      total_cnt++;
      if ({res_valid, res_y00, res_y01, res_y10, res_y11} !==
          {1'b1, 32'sd1, 32'sd4, 32'sd7, e3}) begin
        $display("FAIL stall_hold%0d v=%b got %0d %0d %0d %0d req 1 4 7 %0d",
                 c, res_valid, res_y00, res_y01, res_y10, res_y11, e3);
      end else pass_cnt++;
      tick();
    end
    handshake("stall");
    s_valid = 1'b1;
    tick();
    total_cnt++;
    if ({s_ready, busy} !== 2'b00) begin
      $display("FAIL stall_idle_beat ready,busy=%b required 00",
               {s_ready, busy});
    end else pass_cnt++;
    s_valid = 1'b0;
  endtask

  task automatic test_ignore();
    int base;
    base = issue_cnt;
    lat = 2;
    start_tile(1);
    start = 1'b1;
    k_len = 5'd3;
    stray = 1'b1;
    tick();
    start = 1'b0;
    stray = 1'b0;
    send_beat(3, 1, 2, 4, 0);
    wait_res();
    total_cnt++;
    if ({res_y00, res_y01, res_y10, res_y11} !==
        {32'sd6, 32'sd12, 32'sd2, 32'sd4}) begin
      $display("FAIL ignore_res got %0d %0d %0d %0d required 6 12 2 4",
               res_y00, res_y01, res_y10, res_y11);
    end else pass_cnt++;
    total_cnt++;
    if (issue_cnt - base !== 1) begin
      $display("FAIL ignore_issues got %0d required 1", issue_cnt - base);
    end else pass_cnt++;
    handshake("ignore");
  endtask

  task automatic test_clamp();
    int base;
    base = issue_cnt;
    lat = 1;
    start_tile(20);
    for (int i = 0; i < 16; i++) send_beat(1, 1, 1, 1, 0);
    wait_res();
    total_cnt++;
    if ({res_y00, res_y11, issue_cnt - base} !==
        {32'sd16, 32'sd16, 16}) begin
      $display("FAIL clamp got y00=%0d y11=%0d issues=%0d required 16",
               res_y00, res_y11, issue_cnt - base);
    end else pass_cnt++;
    handshake("clamp");
  endtask

  task automatic test_reset_mid();
    lat = 4;
    start_tile(4);
    send_beat(2, 3, 4, 5, 0);
    tick();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, s_ready, arr_in_valid, res_valid} !== 4'b0000) begin
      $display("FAIL rstmid_ctrl got %b required 0000",
               {busy, s_ready, arr_in_valid, res_valid});
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({arr_a0, arr_a1, arr_b0, arr_b1, arr_acc00, arr_acc11,
         res_y00, res_y11} !== '0) begin
      $display("FAIL rstmid_data a0=%0d b1=%0d res00=%0d required 0",
               arr_a0, arr_b1, res_y00);
    end else pass_cnt++;
    rst_n = 1'b1;
    repeat (6) tick();
    lat = 1;
    start_tile(1);
    send_beat(1, 1, 1, 1, 0);
    wait_res();
    total_cnt++;
    if ({res_y00, res_y01, res_y10, res_y11} !==
        {32'sd1, 32'sd1, 32'sd1, 32'sd1}) begin
      $display("FAIL rstmid_new got %0d %0d %0d %0d required 1 1 1 1",
               res_y00, res_y01, res_y10, res_y11);
    end else pass_cnt++;
    handshake("rstmid");
  endtask

  task automatic test_relu();
    logic signed [31:0] e0, e1;
`ifdef GEMM_SEQ_RELU_EN
    e0 = 32'sd0;
    e1 = 32'sd0;
`else
    e0 = -32'sd8;
    e1 = -32'sd10;
`endif
    lat = 2;
    start_tile(1);
    send_beat(-2, 3, 4, 5, 1);
    wait_res();
    total_cnt++;
    if ({res_y00, res_y01, res_y10, res_y11} !==
        {e0, e1, 32'sd12, 32'sd15}) begin
      $display("FAIL relu_res got %0d %0d %0d %0d required %0d %0d 12 15",
               res_y00, res_y01, res_y10, res_y11, e0, e1);
    end else pass_cnt++;
    handshake("relu");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_kzero();
    test_stall();
    test_ignore();
    test_clamp();
    test_reset_mid();
    test_relu();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
